// File: rtl/single_port_ram_ctrl.sv
// single_port_ram_ctrl: valid/ready bus master for a single-port synchronous RAM with shared tristate data bus
module single_port_ram_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe
);
   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_t;
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    ram_cs_q, ram_cs_d;
   logic                    ram_we_q, ram_we_d;
   logic                    ram_oe_q, ram_oe_d;
   logic                    accept;
   assign req_ready = state_q == IDLE;
   assign accept    = req_valid & req_ready;
   // next state: one cycle per RAM phase, RESP waits for the client
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (req_we ? WR : RD_ADDR) : IDLE;
         WR:      state_d = IDLE;
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: state_d = RESP;
         RESP:    state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // pin values are derived from the next state so they are registered alongside it
   always_comb begin
      ram_addr_d  = accept ? req_addr : ram_addr_q;
      wdata_d     = (accept && req_we) ? req_wdata : wdata_q;
      ram_cs_d    = state_d == WR || state_d == RD_ADDR || state_d == RD_DATA;
      ram_we_d    = state_d == WR;
      ram_oe_d    = state_d == RD_DATA;
      rsp_valid_d = state_d == RESP;
      rsp_rdata_d = (state_q == RD_DATA) ? ram_data : rsp_rdata_q;
   end
   // state and output registers, cleared immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ram_addr_q  <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_valid_q <= 1'b0;
         ram_cs_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_valid_q <= rsp_valid_d;
         ram_cs_q    <= ram_cs_d;
         ram_we_q    <= ram_we_d;
         ram_oe_q    <= ram_oe_d;
      end
   end
   assign ram_data  = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign ram_addr  = ram_addr_q;
   assign ram_cs    = ram_cs_q;
   assign ram_we    = ram_we_q;
   assign ram_oe    = ram_oe_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
endmodule
